// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship damage blocks: FSM encodings,
// LFSR seed/taps and subsystem indices.
package nexys_starship_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_OVER = 3'b100
    } state_e;

    localparam int NUM_SYS = 4;

    localparam logic [1:0] SYS_TOP    = 2'd0;
    localparam logic [1:0] SYS_BOTTOM = 2'd1;
    localparam logic [1:0] SYS_LEFT   = 2'd2;
    localparam logic [1:0] SYS_RIGHT  = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed on the right-shifting register (bits 0,2,3,5).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; the seed is non-zero, so the
// register never reaches the all-zero lock-up state.
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/nexys_starship_damage_sched.sv
// Break/repair scheduler for the four subsystems: random break events,
// repair validation, damage timeout and game-over control.
module nexys_starship_damage_sched
    import nexys_starship_pkg::*;
#(
    parameter int GAP_CYCLES     = 50000000,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int BREAK_THRESH   = 25
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        play_flag,
    input  logic        restart,
    input  logic [1:0]  repair_sel,
    input  logic [3:0]  hex_combo,
    input  logic        repair_btn,
    output logic [3:0]  broken,
    output logic [15:0] combo,
    output logic        repair_ok,
    output logic        repair_fail,
    output logic [7:0]  score,
    output logic        gameover_ctrl,
    output logic        q_Idle,
    output logic        q_Run,
    output logic        q_Over
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT  = AGE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]       THRESH     = 9'(BREAK_THRESH);

    state_e                  state_q;
    logic [NUM_SYS-1:0]      broken_q;
    logic [NUM_SYS-1:0][3:0] combo_q;
    logic [AGE_W-1:0]        age_q [NUM_SYS];
    logic [GAP_W-1:0]        gap_q;
    logic [7:0]              score_q;
    logic                    ok_q;
    logic                    fail_q;

    logic [15:0] lfsr_w;
    logic        lfsr_unused;
    logic        sel_hit;
    logic        rep_ok;
    logic        brk_fire;
    logic [1:0]  brk_idx;
    logic        timeout;

    nexys_starship_lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .lfsr  (lfsr_w)
    );

    assign lfsr_unused = ^lfsr_w[15:14];

    // First free slot scanning start, start+1, ... (mod 4).
    function automatic logic [1:0] pick_slot(input logic [3:0] brk, input logic [1:0] start);
        logic [1:0] idx;
        pick_slot = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (!brk[idx]) pick_slot = idx;
        end
    endfunction

    always_comb begin
        sel_hit  = broken_q[repair_sel] && (hex_combo == combo_q[repair_sel]);
        rep_ok   = repair_btn && sel_hit;
        brk_fire = (gap_q == '0) && (broken_q != 4'hF) && ({1'b0, lfsr_w[7:0]} <= THRESH);
        brk_idx  = pick_slot(broken_q, lfsr_w[9:8]);
        timeout  = 1'b0;
        for (int i = 0; i < NUM_SYS; i++) begin
            if (broken_q[i] && (age_q[i] == AGE_LIMIT) && !(rep_ok && (repair_sel == 2'(i)))) begin
                timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            broken_q <= '0;
            combo_q  <= '0;
            gap_q    <= '0;
            score_q  <= '0;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            for (int i = 0; i < NUM_SYS; i++) age_q[i] <= '0;
        end else begin
            ok_q   <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    broken_q <= '0;
                    combo_q  <= '0;
                    score_q  <= '0;
                    gap_q    <= '0;
                    for (int i = 0; i < NUM_SYS; i++) age_q[i] <= '0;
                    if (play_flag) begin
                        state_q <= ST_RUN;
                        gap_q   <= GAP_RELOAD;
                    end
                end
                ST_RUN: begin
                    if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
                    for (int i = 0; i < NUM_SYS; i++) begin
                        if (broken_q[i]) age_q[i] <= age_q[i] + AGE_W'(1);
                    end
                    if (repair_btn) begin
                        if (sel_hit) begin
                            broken_q[repair_sel] <= 1'b0;
                            ok_q                 <= 1'b1;
                            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                        end else begin
                            fail_q <= 1'b1;
                        end
                    end
                    // brk_idx is never the repaired slot: that slot is still set in broken_q.
                    if (brk_fire) begin
                        broken_q[brk_idx] <= 1'b1;
                        combo_q[brk_idx]  <= lfsr_w[13:10];
                        age_q[brk_idx]    <= '0;
                        gap_q             <= GAP_RELOAD;
                    end
                    if (timeout) state_q <= ST_OVER;
                end
                ST_OVER: begin
                    if (restart) begin
                        state_q  <= ST_IDLE;
                        broken_q <= '0;
                        combo_q  <= '0;
                        score_q  <= '0;
                        gap_q    <= '0;
                        for (int i = 0; i < NUM_SYS; i++) age_q[i] <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign broken        = broken_q;
    assign combo         = combo_q;
    assign score         = score_q;
    assign repair_ok     = ok_q;
    assign repair_fail   = fail_q;
    assign q_Idle        = (state_q == ST_IDLE);
    assign q_Run         = (state_q == ST_RUN);
    assign q_Over        = (state_q == ST_OVER);
    assign gameover_ctrl = (state_q == ST_OVER);

endmodule

// File: doc/nexys_starship_damage_sched.md
Name: nexys_starship_damage_sched

Overview:
Central scheduler for the four subsystem repair blocks: top, bottom, left and right. It decides when a subsystem breaks and which one, and assigns each broken subsystem a random 4-bit repair combo. It also validates the player's repair attempts, times out unrepaired damage and raises game-over. It sits between the top-level play/restart control and the per-subsystem display/repair logic, replacing the independent per-subsystem random break decisions.

Parameters:
NUM_SYS, 4, number of subsystems (fixed at 4 in this revision; index 0=top, 1=bottom, 2=left, 3=right)
GAP_CYCLES, 50000000, minimum cycles between two break events
TIMEOUT_CYCLES, 1000000000, cycles a subsystem may stay broken before game-over
BREAK_THRESH, 25, break fires when lfsr[7:0] <= BREAK_THRESH at gap expiry

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
play_flag  in  1  start request (level)
restart  in  1  single-cycle pulse; leave GAMEOVER
repair_sel  in  2  subsystem the player is currently repairing
hex_combo  in  4  player-entered combo
repair_btn  in  1  single-cycle debounced repair-attempt pulse
broken  out  4  per-subsystem broken flags
combo  out  16  repair combo per subsystem, [4i+3:4i] for subsystem i
repair_ok  out  1  one-cycle pulse: correct repair accepted
repair_fail  out  1  one-cycle pulse: attempt rejected
score  out  8  accepted repairs, saturating at 255
gameover_ctrl  out  1  high for every cycle the block is in GAMEOVER
q_Idle, q_Run, q_Over  out  1 each  one-hot state flags

Behaviour:
- Reset is sampled on the Clk edge while low. It forces state=IDLE, broken=0, combo=0, score=0, and repair_ok=repair_fail=gameover_ctrl=0. It clears the gap counter and all age counters. It sets lfsr=16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle outside reset, in all states, and never reaches zero.
- States are one-hot: IDLE=3'b001, RUN=3'b010, GAMEOVER=3'b100. Any illegal encoding returns to IDLE on the next edge.
- IDLE: broken, combo, score and the counters are held at 0. If play_flag=1, go to RUN and load the gap counter with GAP_CYCLES-1.
- RUN, gap counter: decrements each cycle and stops at 0.
- RUN, break check: runs when gap==0, broken!=4'hF and lfsr[7:0]<=BREAK_THRESH.
  - Start index s=lfsr[9:8].
  - The target is the first i in the order s, s+1, s+2, s+3 (mod 4) with broken[i]==0.
  - Set broken[i]=1, combo[i]=lfsr[13:10], age[i]=0, and reload gap with GAP_CYCLES-1.
  - If the check fails, gap stays at 0 and the check is retried next cycle.
  - If broken==4'hF, no break happens and the gap stays at 0.
- RUN, repair attempt on repair_btn:
  - Accept when broken[repair_sel]==1 and hex_combo==combo[repair_sel]. Clear broken[repair_sel], pulse repair_ok on the next cycle, and increment score (saturating). The stored combo value stays unchanged.
  - Otherwise (wrong combo, or the selected subsystem is not broken), pulse repair_fail. Nothing else changes.
- Same-cycle break and repair: both are applied. The break search uses broken as registered at the start of the cycle, so the break target is never the repaired index.
- Age counters ($clog2(TIMEOUT_CYCLES+1) bits each): age[i] increments every RUN cycle while broken[i]=1. When any age[i] reaches TIMEOUT_CYCLES-1 and that subsystem is still broken (and not repaired this cycle), go to GAMEOVER. A repair in the same cycle wins.
- GAMEOVER: broken, combo and score are frozen; repair_btn is ignored; gameover_ctrl=1. On restart, go to IDLE; IDLE then clears broken, combo and score.
- play_flag dropping during RUN has no effect; only GAMEOVER plus restart, or Reset, leaves RUN.
- Reset mid-RUN takes effect on that edge: all outputs return to their reset values and the next cycle is IDLE.
- Latency: break becomes visible on broken 1 cycle after the qualifying gap==0 cycle. The repair_ok/repair_fail pulse appears 1 cycle after repair_btn.

Decomposition:
- Shared package (nexys_starship_pkg): state encodings, LFSR seed 16'hACE1, tap mask, subsystem index constants (TOP=0, BOTTOM=1, LEFT=2, RIGHT=3).
- One sub-module: nexys_starship_lfsr16. Ports: Clk, Reset, lfsr[15:0]. It is reused by other blocks needing randomness.
- The round-robin free-slot search is a combinational function inside the scheduler.

Test Plan:
- Reset values: hold Reset=0 for 3 cycles -> broken=0, combo=16'h0000, score=0, q_Idle=1, gameover_ctrl=0, and lfsr=16'hACE1 on the first cycle after release.
- First break (GAP_CYCLES=4, BREAK_THRESH=255, TIMEOUT_CYCLES=20): play_flag=1 -> q_Run=1. Exactly one broken bit rises 4 cycles after entering RUN, at index per lfsr[9:8] with combo nibble = lfsr[13:10], checked against a reference-model LFSR.
- Correct repair: set repair_sel to the broken index, hex_combo to its combo, and pulse repair_btn -> next cycle repair_ok=1 for one cycle, broken bit clears, score=1. Then a wrong combo -> repair_fail=1 and broken unchanged.
- Saturation: leave all four broken with no repairs -> broken=4'hF and no further break events. Then 20 cycles after the first break -> gameover_ctrl=1 and q_Over=1. repair_btn is ignored in GAMEOVER; restart -> q_Idle=1 and broken=0.
- Same-cycle collision: force the break check and a correct repair in the same cycle -> the repaired bit clears, a different index sets, and score increments by 1.
- Reset mid-RUN with 2 subsystems broken and score=3 -> next cycle all outputs are at reset values and q_Idle=1.
